// File: rtl/avalon_burst_master_if.sv
// avalon_burst_master_if: Avalon-MM bus between the burst master and a slave.
interface avalon_burst_master_if #(parameter int ADDR_W = 8);
   logic [ADDR_W-1:0] addr;
   logic              read;
   logic              write;
   logic [3:0]        byte_en;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              waitrequest;
   logic              readdatavalid;
   modport master(output addr, read, write, byte_en, writedata, input readdata, waitrequest, readdatavalid);
   modport slave(input addr, read, write, byte_en, writedata, output readdata, waitrequest, readdatavalid);
endinterface

// File: rtl/avalon_burst_master.sv
// avalon_burst_master: moves up to DEPTH words between a local buffer and an Avalon-MM slave.
module avalon_burst_master #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_start_i,
   input  logic                  cmd_dir_i,
   input  logic [ADDR_W-1:0]     cmd_base_i,
   input  logic [4:0]            cmd_len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   avalon_burst_master_if.master avm,
   input  logic                  buf_we_i,
   input  logic [3:0]            buf_addr_i,
   input  logic [31:0]           buf_wdata_i,
   output logic [31:0]           buf_rdata_o
);
   localparam int IW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [4:0] DL = 5'(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, FINISH} state_t;
   state_t            state_q, state_d;
   logic              dir_q, dir_d, err_q, err_d, last;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [4:0]        len_q, len_d, idx_q, idx_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [31:0]       buf_q [DEPTH];
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      last    = idx_q == len_q - 5'd1;
      case (state_q)
         IDLE: if (cmd_start_i) begin
            err_d   = cmd_len_i > DL;
            state_d = (cmd_len_i == 5'd0 || cmd_len_i > DL) ? FINISH : REQ;
            dir_d   = cmd_dir_i;
            base_d  = cmd_base_i;
            len_d   = cmd_len_i;
            idx_d   = '0;
         end
         REQ: if (!avm.waitrequest) begin
            tmr_d   = '0;
            state_d = dir_q ? (last ? FINISH : REQ) : WAIT_DATA;
            idx_d   = dir_q ? idx_q + 5'd1 : idx_q;
         end
         WAIT_DATA: if (avm.readdatavalid) begin
            state_d = last ? FINISH : REQ;
            idx_d   = idx_q + 5'd1;
         end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = FINISH;
            err_d   = 1'b1;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
         FINISH: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
      endcase
   end
   // Bus outputs decode straight from registered state so reset clears them without a clock edge.
   assign busy_o        = state_q == REQ || state_q == WAIT_DATA;
   assign done_o        = state_q == FINISH;
   assign err_o         = done_o && err_q;
   assign avm.read      = state_q == REQ && !dir_q;
   assign avm.write     = state_q == REQ && dir_q;
   assign avm.byte_en   = state_q == REQ ? 4'hF : 4'h0;
   assign avm.addr      = state_q == REQ ? base_q + ADDR_W'(idx_q) : '0;
   assign avm.writedata = avm.write ? buf_q[idx_q[IW-1:0]] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dir_q       <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         tmr_q       <= '0;
         err_q       <= 1'b0;
         buf_rdata_o <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         base_q      <= base_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tmr_q       <= tmr_d;
         err_q       <= err_d;
         buf_rdata_o <= buf_q[buf_addr_i];
      end
   end
   // The engine owns the buffer while busy; user writes only land when idle.
   always_ff @(posedge clk) begin
      if (state_q == WAIT_DATA && avm.readdatavalid)
         buf_q[idx_q[IW-1:0]] <= avm.readdata;
      else if (buf_we_i && !busy_o)
         buf_q[buf_addr_i] <= buf_wdata_i;
   end
endmodule

// File: tb/tb_avalon_burst_master.sv
// tb_avalon_burst_master: directed checks of the burst master against hand-computed values.
module tb_avalon_burst_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_start = 1'b0, cmd_dir = 1'b0;
   logic [7:0]  cmd_base = '0;
   logic [4:0]  cmd_len = '0;
   logic        busy, done, err;
   logic        buf_we = 1'b0;
   logic [3:0]  buf_addr = '0;
   logic [31:0] buf_wdata = '0;
   logic [31:0] buf_rdata;
   int          total = 0, passed = 0;

   avalon_burst_master_if #(.ADDR_W(8)) bus ();

   avalon_burst_master #(.DEPTH(16), .ADDR_W(8), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .cmd_start_i(cmd_start), .cmd_dir_i(cmd_dir), .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
      .busy_o(busy), .done_o(done), .err_o(err),
      .avm(bus.master),
      .buf_we_i(buf_we), .buf_addr_i(buf_addr), .buf_wdata_i(buf_wdata), .buf_rdata_o(buf_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic buf_write(input logic [3:0] a, input logic [31:0] d);
      buf_we = 1'b1; buf_addr = a; buf_wdata = d;
      tick();
      buf_we = 1'b0;
   endtask

   task automatic buf_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
      buf_addr = a;
      tick();
      chk(tag, buf_rdata, exp);
   endtask

   task automatic start(input logic d, input logic [7:0] b, input logic [4:0] l);
      cmd_start = 1'b1; cmd_dir = d; cmd_base = b; cmd_len = l;
      tick();
      cmd_start = 1'b0;
   endtask

   initial begin
      bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bus", {bus.read, bus.write, bus.byte_en, bus.addr}, 0);
      rst = 1'b0;
      tick();

      // write burst with no stalls
      for (int i = 0; i < 4; i++) buf_write(4'(i), 32'hA0 + i);
      start(1'b1, 8'h17, 5'd4);
      for (int i = 0; i < 4; i++) begin
         chk("wr_write", {bus.write, bus.read, busy}, 3'b101);
         chk("wr_addr", bus.addr, 32'h17 + i);
         chk("wr_data", bus.writedata, 32'hA0 + i);
         chk("wr_be", bus.byte_en, 4'hF);
         tick();
      end
      chk("wr_done", {done, err, busy, bus.write}, 4'b1000);
      tick();
      chk("wr_done_pulse", done, 0);

      // read with two stall cycles per request and 3-cycle latency
      bus.waitrequest = 1'b1;
      start(1'b0, 8'h21, 5'd3);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin bus.readdatavalid = 1'b1; bus.readdata = 32'hDEAD; end
         chk("rd_stall1", {bus.read, bus.write}, 2'b10);
         chk("rd_addr1", bus.addr, 32'h21 + i);
         tick();
         bus.readdatavalid = 1'b0;
         chk("rd_addr2", bus.addr, 32'h21 + i);
         tick();
         bus.waitrequest = 1'b0;
         chk("rd_addr3", {bus.read, bus.addr}, {1'b1, 8'h21 + 8'(i)});
         tick();
         bus.waitrequest = 1'b1;
         chk("rd_wait", {bus.read, busy}, 2'b01);
         tick(); tick();
         bus.readdatavalid = 1'b1; bus.readdata = 32'h11 * (i + 1);
         tick();
         bus.readdatavalid = 1'b0;
      end
      chk("rd_done", {done, err}, 2'b10);
      bus.waitrequest = 1'b0;
      tick();
      buf_check(4'd0, 32'h11, "rd_buf0");
      buf_check(4'd1, 32'h22, "rd_buf1");
      buf_check(4'd2, 32'h33, "rd_buf2");

      // address wrap
      start(1'b1, 8'hFE, 5'd4);
      chk("wrap_a0", bus.addr, 32'hFE); tick();
      chk("wrap_a1", bus.addr, 32'hFF); tick();
      chk("wrap_a2", bus.addr, 32'h00); tick();
      chk("wrap_a3", bus.addr, 32'h01); tick();
      chk("wrap_done", {done, err}, 2'b10);
      tick();

      // zero length and oversize length
      start(1'b1, 8'h10, 5'd0);
      chk("len0", {done, err, busy, bus.read, bus.write}, 5'b10000);
      tick();
      chk("len0_idle", {done, busy}, 2'b00);
      start(1'b0, 8'h10, 5'd17);
      chk("len17", {done, err, busy, bus.read, bus.write}, 5'b11000);
      tick();
      chk("len17_pulse", {done, err}, 2'b00);

      // timeout, with ignored START and BUF_WE mid-transfer
      start(1'b0, 8'h40, 5'd2);
      chk("to_req", {bus.read, bus.addr}, {1'b1, 8'h40});
      tick();
      for (int k = 0; k < 255; k++) begin
         if (k == 10) begin
            cmd_start = 1'b1; cmd_dir = 1'b1; cmd_len = 5'd1;
            buf_we = 1'b1; buf_addr = 4'd0; buf_wdata = 32'hBAD;
         end
         if (k == 254) chk("to_early", {done, busy}, 2'b01);
         tick();
         if (k == 10) begin
            cmd_start = 1'b0; buf_we = 1'b0;
            chk("ign_busy", {busy, bus.write, bus.read}, 3'b100);
         end
      end
      chk("to_done", {done, err, busy, bus.read}, 4'b1100);
      tick();
      buf_check(4'd0, 32'h11, "ign_buf0");

      // asynchronous reset during WAIT_DATA
      buf_addr = 4'd1;
      start(1'b0, 8'h50, 5'd2);
      tick();
      chk("pre_rst", {busy, buf_rdata}, {1'b1, 32'h22});
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", {busy, done, err}, 3'b000);
      chk("async_rst_bus", {bus.read, bus.write, bus.byte_en, bus.addr}, 0);
      chk("async_rst_rdata", buf_rdata, 0);
      #1 rst = 1'b0;
      tick();
      start(1'b0, 8'h60, 5'd1);
      chk("post_rst_req", {bus.read, bus.addr}, {1'b1, 8'h60});
      tick();
      bus.readdatavalid = 1'b1; bus.readdata = 32'h5A;
      tick();
      bus.readdatavalid = 1'b0;
      chk("post_rst_done", {done, err}, 2'b10);
      tick();
      buf_check(4'd0, 32'h5A, "post_rst_buf0");
      buf_check(4'd1, 32'h22, "post_rst_buf1");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/avalon_burst_master.md
Name: avalon_burst_master

Overview:
- Avalon-MM master: the initiator counterpart to the body regfile slave.
- Moves a contiguous window of up to DEPTH 32-bit words between a local buffer and any Avalon-MM slave address range.
- Used to snapshot body state (positions, velocities) out of a slave regfile, or to bulk-load initial body data into one, without a CPU.
- One transaction in flight at a time; honours waitrequest and variable read latency (readdatavalid).

Parameters:
DEPTH, 16, local buffer words; maximum transfer length
ADDR_W, 8, Avalon word address width
TIMEOUT, 255, max cycles to wait for readdatavalid before aborting

Ports:
CLK  in  1  system clock (50 MHz)
RESET  in  1  asynchronous, active-high reset
CMD_START  in  1  one-cycle pulse; starts a transfer when idle
CMD_DIR  in  1  0 = read slave into buffer, 1 = write buffer to slave
CMD_BASE  in  ADDR_W  first slave word address
CMD_LEN  in  5  word count, 0..31
BUSY  out  1  transfer in progress
DONE  out  1  one-cycle completion pulse
ERR  out  1  one-cycle error pulse, coincident with DONE
AVM_ADDR  out  ADDR_W  master address
AVM_READ  out  1  read request
AVM_WRITE  out  1  write request
AVM_BYTE_EN  out  4  byte enables, always 4'b1111 while READ or WRITE is high, else 0
AVM_WRITEDATA  out  32  write data
AVM_READDATA  in  32  read data
AVM_WAITREQUEST  in  1  slave stall
AVM_READDATAVALID  in  1  read data valid
BUF_WE  in  1  user write strobe into buffer
BUF_ADDR  in  4  user buffer index
BUF_WDATA  in  32  user write data
BUF_RDATA  out  32  buffer[BUF_ADDR], registered, 1-cycle latency

Behaviour:
- Reset is asynchronous: state goes to IDLE immediately. BUSY, DONE, ERR, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA and BUF_RDATA all go to 0. Buffer contents are not cleared.
- States:
  - IDLE: BUSY=0.
    - CMD_START sampled with CMD_LEN=0: go to FINISH. No bus activity.
    - CMD_START sampled with CMD_LEN>DEPTH: go to FINISH with ERR set.
    - Otherwise: latch dir/base/len, set idx=0, go to REQ.
  - REQ: BUSY=1. AVM_ADDR=base+idx, truncated to ADDR_W (wraps, e.g. 0xFF+1 = 0x00). Assert AVM_WRITE with AVM_WRITEDATA=buf[idx] (dir=1), or AVM_READ (dir=0).
    - While AVM_WAITREQUEST=1: ADDR, WRITEDATA and READ/WRITE are held stable.
    - On the cycle WAITREQUEST=0 (accepted), write path: if idx==len-1 go to FINISH, else idx++ and stay in REQ. Back-to-back writes issue with no idle cycle.
    - On acceptance, read path: go to WAIT_DATA and clear the timer.
    - READDATAVALID is ignored in REQ.
  - WAIT_DATA: READ deasserted; timer increments each cycle.
    - On READDATAVALID: buf[idx]<=AVM_READDATA. If idx==len-1 go to FINISH, else idx++ and go to REQ.
    - If the timer reaches TIMEOUT with no READDATAVALID: go to FINISH with ERR. Partial buffer contents are kept.
  - FINISH: DONE=1 (and ERR=1 if flagged) for exactly one cycle, BUSY=0, then IDLE.
- Timing: CMD_START sampled at edge n gives BUSY=1 and the first request from cycle n+1. A length-N write with no waitrequest holds WRITE high for cycles n+1..n+N, with DONE at n+N+1.
- CMD_START while not IDLE is ignored. Command inputs are sampled only on the accepting cycle.
- BUF_WE while BUSY=1 is ignored (the engine owns buffer writes). BUF_RDATA is always live, including during a transfer.
- READ and WRITE are never high together.

Test Plan:
- Write burst: buf[0..3]=0xA0..0xA3, start dir=1 base=0x17 len=4, WAITREQUEST=0 -> WRITE high for 4 consecutive cycles, ADDR 0x17..0x1A, data 0xA0..0xA3, BYTE_EN=0xF, DONE one cycle later, ERR=0.
- Read with stalls: base=0x21 len=3, WAITREQUEST high for 2 cycles per request, READDATAVALID 3 cycles after acceptance with data 0x11, 0x22, 0x33 -> ADDR stable during stalls; BUF_RDATA at indices 0..2 returns 0x11, 0x22, 0x33 after DONE.
- Wrap and limits: base=0xFE len=4 write -> addresses 0xFE, 0xFF, 0x00, 0x01. len=0 -> DONE next cycle, no bus activity. len=17 -> DONE+ERR, no bus activity.
- Timeout: read len=2, READDATAVALID never asserted -> after 255 cycles in WAIT_DATA, DONE+ERR pulse, READ low, BUSY 0.
- Reset mid-transfer: assert RESET during WAIT_DATA -> all outputs 0 immediately without a clock edge. After release, a new len=1 read completes normally.
- Ignored inputs: CMD_START and BUF_WE pulsed while BUSY -> no effect on the current transfer or buffer contents.
